sort_ip_seq: RTL and testbench
==============================

Name: sort_ip_seq

Overview:
- Clocked, parametrised successor to the combinational character/weight sort IP.
- Accepts one vector of IP_WIDTH (character, weight) pairs through a valid/ready handshake.
- Sorts the pairs iteratively with odd-even transposition, one pass per cycle, in a run-time selectable order.
- Returns the sorted characters together with their weights, held under output backpressure; used where a sort must be time-multiplexed instead of fully unrolled.

Parameters:
- IP_WIDTH, 8, number of elements per vector (>= 2).
- CHAR_W, 4, character width in bits.
- WEIGHT_W, 5, weight width in bits.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  input vector valid.
- in_ready  output  1  block can accept a vector.
- in_mode  input  1  0 = descending, 1 = ascending; sampled at accept.
- in_character  input  IP_WIDTH*CHAR_W  characters; element i at bits [(IP_WIDTH-1-i)*CHAR_W +: CHAR_W], element 0 at MSB.
- in_weight  input  IP_WIDTH*WEIGHT_W  weights, same packing as in_character.
- out_valid  output  1  sorted result valid.
- out_ready  input  1  consumer accepts result.
- out_character  output  IP_WIDTH*CHAR_W  sorted characters; position 0 at MSB.
- out_weight  output  IP_WIDTH*WEIGHT_W  weights matching out_character.

Behaviour:
- **Reset** (rst high at an edge): state IDLE, pass counter 0, element registers 0, mode register 0.
  - Outputs after reset: in_ready=1, out_valid=0, out_character=0, out_weight=0.
  - Reset overrides every other event, including an abort mid-SORT or mid-DONE. Any partial result is discarded.
- **Sort key:** {weight, character}, width WEIGHT_W+CHAR_W, unsigned. Weight is primary; character value breaks ties.
- **States:** IDLE, SORT, DONE. in_ready = (state==IDLE). out_valid = (state==DONE).
- **IDLE:**
  - On edge with in_valid=1: load all pairs, latch in_mode, clear pass counter, go to SORT.
  - in_valid=0: hold.
- **SORT:** one compare-swap pass per cycle, passes p = 0 .. IP_WIDTH-1.
  - Even p compares pairs (0,1),(2,3),...
  - Odd p compares pairs (1,2),(3,4),...
  - An unpaired end element is untouched.
  - Descending: swap the pair (i,i+1) when key[i] < key[i+1].
  - Ascending: swap the pair (i,i+1) when key[i] > key[i+1].
  - Equal keys never swap.
  - On the edge executing p = IP_WIDTH-1, go to DONE.
  - in_valid is ignored during SORT.
- **DONE:**
  - out_character/out_weight driven from the element registers, stable while out_valid=1.
  - On edge with out_ready=1: go to IDLE; out_valid drops the next cycle and in_ready rises the same cycle.
  - out_ready=0: hold indefinitely, with no change to data.
- **Latency:** accept at edge k; out_valid first high in the cycle after edge k+IP_WIDTH, i.e. IP_WIDTH+1 cycles after the accept cycle.
- **Throughput:** at most one vector per IP_WIDTH+2 cycles. No overlap of accept and drain; an in_valid in the same cycle as the output handshake is not accepted.
- **Outputs outside DONE:** out_character/out_weight hold the register contents but carry no meaning.
- **Counter:** pass counter is $clog2(IP_WIDTH) bits wide and has no wrap hazard, since the DONE transition happens at IP_WIDTH-1.
- **Result:** a permutation of the input pairs; each character stays bound to its own weight.

Test Plan:
1. **Descending sort.** Reset, then mode=0, in_character=32'h01234567, weights (pos0..7) = 3,7,1,7,0,5,2,6.
   - Required: out_character=32'h31750624, out_weight=7,7,6,5,3,2,1,0.
   - Required: out_valid rises exactly 9 cycles after the accept cycle.
2. **Ascending sort.** Same vector with mode=1.
   - Required: out_character=32'h42605713, out_weight=0,1,2,3,5,6,7,7.
3. **Backpressure.** Hold out_ready=0 for 20 cycles in DONE, then pulse it.
   - Required: outputs constant throughout, in_ready=0 throughout.
   - Required: in_ready=1 the cycle after the handshake.
4. **In_valid ignored while busy.** Toggle in_valid with different data during SORT and DONE.
   - Required: result identical to scenario 1; no second accept until IDLE.
5. **Reset mid-operation.** Assert rst at pass 3 of a sort.
   - Required: next cycle in_ready=1, out_valid=0, outputs 0.
   - Required: the following vector sorts correctly.
6. **Degenerate inputs.** All weights equal (5), characters 7,6,...,0, mode=0.
   - Required: out_character=32'h76543210 (order decided by character tie-break).
   - Then all keys identical: output equals input, no spurious swaps.

Source files
------------

// File: rtl/sort_ip_seq.sv
// sort_ip_seq -- sequential (character, weight) sorter.
//
// Accepts one vector of IP_WIDTH (character, weight) pairs over a valid/ready
// handshake, sorts it with odd-even transposition (one compare-swap pass per
// cycle, IP_WIDTH passes), then presents the result until the consumer takes
// it. Sort key is {weight, character}, unsigned; weight is primary and the
// character breaks ties. Equal keys are never swapped.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_ready input handshake; in_ready is high only in IDLE
//   in_mode           0 = descending, 1 = ascending (latched at accept)
//   in_character      IP_WIDTH x CHAR_W, element 0 in the MSBs
//   in_weight         IP_WIDTH x WEIGHT_W, same packing
//   out_valid/out_ready output handshake; out_valid is high only in DONE
//   out_character     sorted characters, position 0 in the MSBs
//   out_weight        weights bound to out_character
module sort_ip_seq #(
    parameter int IP_WIDTH = 8,
    parameter int CHAR_W   = 4,
    parameter int WEIGHT_W = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         in_mode,
    input  logic [IP_WIDTH*CHAR_W-1:0]   in_character,
    input  logic [IP_WIDTH*WEIGHT_W-1:0] in_weight,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [IP_WIDTH*CHAR_W-1:0]   out_character,
    output logic [IP_WIDTH*WEIGHT_W-1:0] out_weight
);

    localparam int CW = $clog2(IP_WIDTH);
    localparam int KW = WEIGHT_W + CHAR_W;

    typedef enum logic [1:0] {IDLE, SORT, DONE} state_t;

    state_t              state_q;
    logic [CW-1:0]       pass_q;
    logic                mode_q;
    logic [CHAR_W-1:0]   chr_q [IP_WIDTH];
    logic [WEIGHT_W-1:0] wgt_q [IP_WIDTH];
    logic [CHAR_W-1:0]   chr_d [IP_WIDTH];
    logic [WEIGHT_W-1:0] wgt_d [IP_WIDTH];

    function automatic logic need_swap(input logic [KW-1:0] a,
                                       input logic [KW-1:0] b,
                                       input logic asc);
        return asc ? (a > b) : (a < b);
    endfunction

    // One transposition pass. Only pairs whose left index has the same parity
    // as the pass number are compared, so the pairs never overlap and an
    // unpaired end element falls through unchanged.
    always_comb begin
        for (int i = 0; i < IP_WIDTH; i++) begin
            chr_d[i] = chr_q[i];
            wgt_d[i] = wgt_q[i];
        end
        for (int i = 0; i < IP_WIDTH - 1; i++) begin
            if (i[0] == pass_q[0] &&
                need_swap({wgt_q[i], chr_q[i]}, {wgt_q[i+1], chr_q[i+1]}, mode_q)) begin
                chr_d[i]   = chr_q[i+1];
                wgt_d[i]   = wgt_q[i+1];
                chr_d[i+1] = chr_q[i];
                wgt_d[i+1] = wgt_q[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pass_q  <= '0;
            mode_q  <= 1'b0;
            for (int i = 0; i < IP_WIDTH; i++) begin
                chr_q[i] <= '0;
                wgt_q[i] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        for (int i = 0; i < IP_WIDTH; i++) begin
                            chr_q[i] <= in_character[(IP_WIDTH-1-i)*CHAR_W +: CHAR_W];
                            wgt_q[i] <= in_weight[(IP_WIDTH-1-i)*WEIGHT_W +: WEIGHT_W];
                        end
                        mode_q  <= in_mode;
                        pass_q  <= '0;
                        state_q <= SORT;
                    end
                end
                SORT: begin
                    for (int i = 0; i < IP_WIDTH; i++) begin
                        chr_q[i] <= chr_d[i];
                        wgt_q[i] <= wgt_d[i];
                    end
                    // Counter may wrap after the last pass; it is cleared at
                    // the next accept, so the wrapped value is never used.
                    pass_q <= pass_q + 1'b1;
                    if (pass_q == CW'(IP_WIDTH - 1))
                        state_q <= DONE;
                end
                DONE: begin
                    if (out_ready)
                        state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);

    always_comb begin
        out_character = '0;
        out_weight    = '0;
        for (int i = 0; i < IP_WIDTH; i++) begin
            out_character[(IP_WIDTH-1-i)*CHAR_W +: CHAR_W]  = chr_q[i];
            out_weight[(IP_WIDTH-1-i)*WEIGHT_W +: WEIGHT_W] = wgt_q[i];
        end
    end

endmodule

// File: tb/tb_sort_ip_seq.sv
// Testbench for sort_ip_seq (default parameters: 8 elements, 4-bit chars,
// 5-bit weights). The driver pushes hand-computed expected results into a
// scoreboard queue at accept time; a separate monitor pops and compares when
// out_valid first rises, and also checks the accept-to-valid latency.
module tb_sort_ip_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_mode;
    logic [31:0] in_character;
    logic [39:0] in_weight;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_character;
    logic [39:0] out_weight;

    sort_ip_seq #(.IP_WIDTH(8), .CHAR_W(4), .WEIGHT_W(5)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
        .in_character(in_character), .in_weight(in_weight),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_character(out_character), .out_weight(out_weight)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] ch;
        logic [39:0] wt;
        int          acc;   // cycle count value of the accepting edge
    } exp_t;

    exp_t sb[$];
    int   tot = 0;
    int   bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tot++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [39:0] pkw(input int a0, a1, a2, a3, a4, a5, a6, a7);
        return {5'(a0), 5'(a1), 5'(a2), 5'(a3), 5'(a4), 5'(a5), 5'(a6), 5'(a7)};
    endfunction

    // Monitor: compare on the first cycle out_valid is seen high.
    logic seen = 1'b0;
    always @(negedge clk) begin
        if (rst || !out_valid) begin
            seen = 1'b0;
        end else if (!seen) begin
            exp_t e;
            seen = 1'b1;
            if (sb.size() == 0) begin
                chk("unexpected_output", 64'(out_character), 64'hDEAD);
            end else begin
                e = sb.pop_front();
                chk("out_character", 64'(out_character), 64'(e.ch));
                chk("out_weight", 64'(out_weight), 64'(e.wt));
                // Last edge seen is k+8; out_valid is high in the cycle ending
                // at edge k+9, i.e. 9 cycles after the accept cycle.
                chk("latency", 64'(cyc + 1 - e.acc), 64'd9);
            end
        end
    end

    task automatic send(input logic m, input logic [31:0] c, input logic [39:0] w,
                        input logic [31:0] ec, input logic [39:0] ew);
        int n = 0;
        exp_t e;
        @(negedge clk);
        in_mode = m; in_character = c; in_weight = w; in_valid = 1'b1;
        while (!in_ready && n < 100) begin @(negedge clk); n++; end
        if (!in_ready) begin
            chk("accept_timeout", 64'(in_ready), 64'd1);
        end else begin
            e.ch = ec; e.wt = ew; e.acc = cyc + 1;
            sb.push_back(e);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((sb.size() != 0 || out_valid) && n < 300) begin @(negedge clk); n++; end
        if (n >= 300) chk("drain_timeout", 64'(sb.size()), 64'd0);
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!out_valid && n < 100) begin @(negedge clk); n++; end
        if (!out_valid) chk("valid_timeout", 64'(out_valid), 64'd1);
    endtask

    localparam logic [31:0] C1  = 32'h01234567;
    localparam logic [31:0] CD  = 32'h31750624;
    localparam logic [31:0] CA  = 32'h42605713;

    initial begin
        logic [39:0] w1, wd, wa, w5, w9;
        w1 = pkw(3, 7, 1, 7, 0, 5, 2, 6);
        wd = pkw(7, 7, 6, 5, 3, 2, 1, 0);
        wa = pkw(0, 1, 2, 3, 5, 6, 7, 7);
        w5 = pkw(5, 5, 5, 5, 5, 5, 5, 5);
        w9 = pkw(9, 9, 9, 9, 9, 9, 9, 9);

        rst = 1'b1; in_valid = 1'b0; in_mode = 1'b0; out_ready = 1'b1;
        in_character = '0; in_weight = '0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_char", 64'(out_character), 64'd0);
        chk("rst_out_weight", 64'(out_weight), 64'd0);
        rst = 1'b0;

        // 1. descending
        send(1'b0, C1, w1, CD, wd);
        wait_drain();

        // 2. ascending
        send(1'b1, C1, w1, CA, wa);
        wait_drain();

        // 3. backpressure: hold 20 cycles in DONE, then release
        out_ready = 1'b0;
        send(1'b1, C1, w1, CA, wa);
        wait_valid();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("bp_char", 64'(out_character), 64'(CA));
            chk("bp_weight", 64'(out_weight), 64'(wa));
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_out_valid", 64'(out_valid), 64'd1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_in_ready", 64'(in_ready), 64'd1);
        chk("bp_release_out_valid", 64'(out_valid), 64'd0);
        wait_drain();

        // 4. in_valid toggled with garbage while busy
        send(1'b0, C1, w1, CD, wd);
        for (int i = 0; i < 30 && !out_valid; i++) begin
            in_valid = ~in_valid;
            in_mode = ~in_mode;
            in_character = 32'hFFFF0000 ^ 32'(cyc);
            in_weight = 40'hAB_CDEF_0123 ^ 40'(cyc);
            @(negedge clk);
        end
        // in_valid high across the output handshake edge must not be accepted
        in_valid = 1'b1;
        @(negedge clk);
        chk("busy_no_accept_in_ready", 64'(in_ready), 64'd1);
        chk("busy_no_accept_out_valid", 64'(out_valid), 64'd0);
        in_valid = 1'b0;
        wait_drain();

        // 5. reset mid-sort, at the edge that would execute pass 3
        send(1'b0, C1, w1, CD, wd);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_out_char", 64'(out_character), 64'd0);
        chk("mid_rst_out_weight", 64'(out_weight), 64'd0);
        sb.delete();
        rst = 1'b0;
        send(1'b0, C1, w1, CD, wd);
        wait_drain();

        // 6. degenerate inputs
        send(1'b0, 32'h76543210, w5, 32'h76543210, w5);
        wait_drain();
        send(1'b1, 32'h76543210, w5, 32'h01234567, w5);
        wait_drain();
        send(1'b0, 32'h33333333, w9, 32'h33333333, w9);
        wait_drain();
        send(1'b1, 32'h33333333, w9, 32'h33333333, w9);
        wait_drain();

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
